layer_ctrl: RTL

//  Sequences one fully-connected layer of neuron instances. Buffers one input vector, broadcasts
//  it sample-by-sample to all neurons, collects each neuron's result on its outValid pulse, and

---
 rtl/layer_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/layer_ctrl.sv
// layer_ctrl: buffers one input vector, broadcasts it to a layer of neurons, collects each
// neuron's first result and streams them out over valid/ready. Option macro: LAYER_TIMEOUT_EN.
module layer_ctrl #(
  parameter int numInputs  = 784,
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int timeoutCyc = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_wr,
  input  logic [dataWidth-1:0]            in_data,
  input  logic                            start,
  output logic                            busy,
  output logic                            in_full,
  output logic [dataWidth-1:0]            x_out,
  output logic                            x_valid,
  input  logic [numNeurons*dataWidth-1:0] n_out,
  input  logic [numNeurons-1:0]           n_valid,
  output logic [dataWidth-1:0]            res_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            done,
  output logic                            err
);
  localparam int AW = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int PW = $clog2(numInputs) + 1;
  localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [PW-1:0] LP_NI   = PW'(numInputs);
  localparam logic [IW-1:0] LP_LAST = IW'(numNeurons - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [numNeurons-1:0] r_mask;
  logic [IW-1:0]         r_idx;
  logic                  r_x_vld;
  logic [dataWidth-1:0]  r_x_dat;
  logic                  r_done;
  logic [dataWidth-1:0]  r_buf [numInputs];
  logic [dataWidth-1:0]  r_res [numNeurons];

  logic                  w_wr;
  logic                  w_collect;
  logic [numNeurons-1:0] w_cap;
  logic                  w_to_fire;

  assign in_full   = (r_wr_ptr == LP_NI);
  assign busy      = (r_state != S_IDLE);
  assign w_wr      = (r_state == S_IDLE) && in_wr && !in_full;
  assign w_collect = (r_state == S_STREAM) || (r_state == S_WAIT);
  assign w_cap     = w_collect ? (n_valid & ~r_mask) : '0;
  assign x_valid   = r_x_vld;
  assign x_out     = r_x_dat;
  assign done      = r_done;
  assign res_valid = (r_state == S_DRAIN);
  assign res_data  = res_valid ? r_res[r_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wr_ptr[AW-1:0]] <= in_data;
  end

  // Only the first pulse per neuron lands; a watchdog expiry zero-fills the stragglers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < numNeurons; k++) begin
      if (w_to_fire && !r_mask[k]) r_res[k] <= '0;
      else if (w_cap[k])           r_res[k] <= n_out[k*dataWidth +: dataWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mask   <= '0;
      r_idx    <= '0;
      r_x_vld  <= 1'b0;
      r_x_dat  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mask <= r_mask | w_cap;
      case (r_state)
        S_IDLE: begin
          if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (start && in_full) begin
            r_state  <= S_STREAM;
            r_x_vld  <= 1'b1;
            r_x_dat  <= r_buf[0];
            r_rd_ptr <= PW'(1);
          end
        end
        S_STREAM: begin
          // The burst must be exactly numInputs back-to-back samples.
          if (r_rd_ptr == LP_NI) begin
            r_x_vld  <= 1'b0;
            r_wr_ptr <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_x_dat  <= r_buf[r_rd_ptr[AW-1:0]];
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        S_WAIT: begin
          if ((&r_mask) || w_to_fire) r_state <= S_DRAIN;
        end
        default: begin
          if (res_ready) begin
            if (r_idx == LP_LAST) begin
              r_idx   <= '0;
              r_mask  <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef LAYER_TIMEOUT_EN
  localparam int TW = $clog2(timeoutCyc) + 1;
  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  assign w_to_fire = (r_state == S_WAIT) && !(&r_mask) && (r_to_cnt == TW'(timeoutCyc - 1));
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_to_cnt <= '0;
      else                   r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_fire) r_err <= 1'b1;
    end
  end
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = 32'(timeoutCyc);
  assign w_to_fire   = 1'b0;
  assign err         = 1'b0;
`endif
endmodule
